// File: rtl/mc_main_ctrl.sv
// Multi-cycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback.
// Optional MEM_READY_EN adds a MemReady handshake that stretches FETCH, MEMRD and MEMWR.
module mc_main_ctrl #(
  parameter int OP_W    = 6,
  parameter int STATE_W = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [OP_W-1:0]    Op,
  input  logic               Zero,
`ifdef MEM_READY_EN
  input  logic               MemReady,
`endif
  output logic               PCWrite,
  output logic               Branch,
  output logic               IorD,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic [1:0]         PCSrc,
  output logic               ExtOp,
  output logic               InstrDone,
  output logic               Illegal,
  output logic [STATE_W-1:0] State
);

  typedef enum logic [STATE_W-1:0] {
    IDLE    = STATE_W'(0),
    FETCH   = STATE_W'(1),
    DECODE  = STATE_W'(2),
    MEMADR  = STATE_W'(3),
    MEMRD   = STATE_W'(4),
    MEMWB   = STATE_W'(5),
    MEMWR   = STATE_W'(6),
    RTYPEEX = STATE_W'(7),
    RTYPEWB = STATE_W'(8),
    BEQEX   = STATE_W'(9),
    IMMEX   = STATE_W'(10),
    IMMWB   = STATE_W'(11),
    JEX     = STATE_W'(12)
  } state_t;

  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_ORI  = OP_W'(6'b001101);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);

  state_t          state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;
  logic            mem_rdy;
  logic            is_ori;
  logic            unused_zero;

  // Zero is consumed by the datapath's branch gating, not by the sequencer.
  assign unused_zero = Zero;

`ifdef MEM_READY_EN
  assign mem_rdy = MemReady;
`else
  assign mem_rdy = 1'b1;
`endif

  assign is_ori = (op_q == OP_ORI);
  assign State  = state_q;
  assign op_d   = (state_q == DECODE) ? Op : op_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    PCWrite   = 1'b0;
    Branch    = 1'b0;
    IorD      = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegDst    = 1'b0;
    MemtoReg  = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    PCSrc     = 2'b00;
    ExtOp     = (state_q != IDLE);
    InstrDone = 1'b0;
    Illegal   = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        // IR/PC loads only fire on the cycle the memory actually returns data.
        ALUSrcB = 2'b01;
        IRWrite = mem_rdy;
        PCWrite = mem_rdy;
        if (mem_rdy) state_d = DECODE;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (Op)
          OP_LW, OP_SW:    state_d = MEMADR;
          OP_R:            state_d = RTYPEEX;
          OP_BEQ:          state_d = BEQEX;
          OP_ADDI, OP_ORI: state_d = IMMEX;
          OP_J:            state_d = JEX;
          default: begin
            state_d = FETCH;
            Illegal = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (op_q == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        IorD = 1'b1;
        if (mem_rdy) state_d = MEMWB;
      end
      MEMWB: begin
        RegWrite  = 1'b1;
        MemtoReg  = 1'b1;
        InstrDone = 1'b1;
        state_d   = FETCH;
      end
      MEMWR: begin
        // Strobe stays up for the whole wait; completion marks the accepting cycle.
        IorD      = 1'b1;
        MemWrite  = 1'b1;
        InstrDone = mem_rdy;
        if (mem_rdy) state_d = FETCH;
      end
      RTYPEEX: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = RTYPEWB;
      end
      RTYPEWB: begin
        RegDst    = 1'b1;
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
        state_d   = FETCH;
      end
      BEQEX: begin
        ALUSrcA   = 1'b1;
        ALUOp     = 2'b01;
        PCSrc     = 2'b01;
        Branch    = 1'b1;
        InstrDone = 1'b1;
        state_d   = FETCH;
      end
      IMMEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = is_ori ? 2'b11 : 2'b00;
        ExtOp   = ~is_ori;
        state_d = IMMWB;
      end
      IMMWB: begin
        // Extender mode held so the writeback sees the same immediate.
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
        ExtOp     = ~is_ori;
        state_d   = FETCH;
      end
      JEX: begin
        PCWrite   = 1'b1;
        PCSrc     = 2'b10;
        InstrDone = 1'b1;
        state_d   = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Randomized instruction stream against a per-instruction expected-cycle model.
module tb_mc_main_ctrl;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000, ORI = 6'b001101, J = 6'b000010;
  localparam logic [17:0] HOLD_MASK = 18'h20000 | 18'h02000 | 18'h00002;

  logic       CLK = 1'b0;
  logic       RST;
  logic [5:0] Op;
  logic       Zero;
`ifdef MEM_READY_EN
  logic       MemReady;
`endif
  logic       PCWrite, Branch, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic       ExtOp, InstrDone, Illegal;
  logic [3:0] State;

  always #5 CLK = ~CLK;

  mc_main_ctrl dut (
    .CLK(CLK), .RST(RST), .Op(Op), .Zero(Zero),
`ifdef MEM_READY_EN
    .MemReady(MemReady),
`endif
    .PCWrite(PCWrite), .Branch(Branch), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .ExtOp(ExtOp), .InstrDone(InstrDone),
    .Illegal(Illegal), .State(State)
  );

  wire [17:0] outs = {PCWrite, Branch, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                      ALUSrcA, ALUSrcB, ALUOp, PCSrc, ExtOp, InstrDone, Illegal};

  typedef struct { int st; logic [17:0] o; logic rdy; logic [5:0] op; } rec_t;
  rec_t       q[$];
  logic [5:0] cur_op;
  int total = 0, bad = 0, seen_done = 0, exp_done = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic legal(input logic [5:0] op);
    return op inside {LW, SW, RT, BEQ, ADDI, ORI, J};
  endfunction

  // Output vector, same order as 'outs'.
  function automatic logic [17:0] o(input logic pcw, br, iord, mw, irw, rdst, m2r, rw, asa,
                                    input logic [1:0] asb, aop, pcs,
                                    input logic ext, done, ill);
    return {pcw, br, iord, mw, irw, rdst, m2r, rw, asa, asb, aop, pcs, ext, done, ill};
  endfunction

  task automatic push(input int st, input logic [17:0] v, input bit mem);
    int w;
    w = 0;
`ifdef MEM_READY_EN
    if (mem) w = $urandom_range(0, 3);
`else
    if (mem) w = 0;
`endif
    for (int i = 0; i < w; i++) q.push_back('{st, v & ~HOLD_MASK, 1'b0, cur_op});
    q.push_back('{st, v, 1'b1, cur_op});
  endtask

  // Expected cycle list for one instruction, FETCH through its done state.
  task automatic build(input logic [5:0] op);
    logic ori;
    ori = (op == ORI);
    cur_op = op;
    push(1, o(1,0,0,0,1,0,0,0,0, 2'b01,2'b00,2'b00, 1,0,0), 1);
    push(2, o(0,0,0,0,0,0,0,0,0, 2'b11,2'b00,2'b00, 1,0,!legal(op)), 0);
    if (legal(op)) exp_done++;
    case (op)
      LW: begin
        push(3, o(0,0,0,0,0,0,0,0,1, 2'b10,2'b00,2'b00, 1,0,0), 0);
        push(4, o(0,0,1,0,0,0,0,0,0, 2'b00,2'b00,2'b00, 1,0,0), 1);
        push(5, o(0,0,0,0,0,0,1,1,0, 2'b00,2'b00,2'b00, 1,1,0), 0);
      end
      SW: begin
        push(3, o(0,0,0,0,0,0,0,0,1, 2'b10,2'b00,2'b00, 1,0,0), 0);
        push(6, o(0,0,1,1,0,0,0,0,0, 2'b00,2'b00,2'b00, 1,1,0), 1);
      end
      RT: begin
        push(7, o(0,0,0,0,0,0,0,0,1, 2'b00,2'b10,2'b00, 1,0,0), 0);
        push(8, o(0,0,0,0,0,1,0,1,0, 2'b00,2'b00,2'b00, 1,1,0), 0);
      end
      BEQ: push(9, o(0,1,0,0,0,0,0,0,1, 2'b00,2'b01,2'b01, 1,1,0), 0);
      ADDI, ORI: begin
        push(10, o(0,0,0,0,0,0,0,0,1, 2'b10, ori ? 2'b11 : 2'b00, 2'b00, !ori,0,0), 0);
        push(11, o(0,0,0,0,0,0,0,1,0, 2'b00,2'b00,2'b00, !ori,1,0), 0);
      end
      J: push(12, o(1,0,0,0,0,0,0,0,0, 2'b00,2'b00,2'b10, 1,1,0), 0);
      default: ;
    endcase
  endtask

  task automatic step(input rec_t r);
    Op   = (r.st == 2) ? r.op : 6'($urandom);
    Zero = 1'($urandom);
`ifdef MEM_READY_EN
    MemReady = r.rdy;
`endif
    @(negedge CLK);
    chk("state", 32'(State), 32'(r.st));
    chk($sformatf("outs_st%0d_op%02h", r.st, r.op), 32'(outs), 32'(r.o));
    if (InstrDone) seen_done++;
    @(posedge CLK); #1;
  endtask

  task automatic drain();
    while (q.size() != 0) step(q.pop_front());
  endtask

  function automatic logic [5:0] rand_op();
    logic [5:0] ops[7] = '{LW, SW, RT, BEQ, ADDI, ORI, J};
    logic [5:0] op;
    int k;
    k = $urandom_range(0, 7);
    if (k < 7) return ops[k];
    do op = 6'($urandom); while (legal(op));
    return op;
  endfunction

  initial begin
    logic [5:0] dir[8] = '{LW, ORI, ADDI, BEQ, 6'b111111, SW, RT, J};
    RST = 1'b1; Op = 6'b111111; Zero = 1'b0;
    cur_op = '0;
`ifdef MEM_READY_EN
    MemReady = 1'b0;
`endif
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_state", 32'(State), 32'd0);
    chk("rst_outs", 32'(outs), 32'd0);
    @(posedge CLK); #1 RST = 1'b0;

    q.push_back('{0, 18'd0, 1'b1, 6'd0});
    foreach (dir[i]) build(dir[i]);
    drain();
    for (int n = 0; n < 40; n++) begin
      build(rand_op());
      drain();
    end

    // Reset in the middle of a store.
    build(SW);
    while (q.size() != 0 && q[0].st != 6) step(q.pop_front());
    q.delete();
    Op = 6'($urandom);
`ifdef MEM_READY_EN
    MemReady = 1'b0;
`endif
    @(negedge CLK);
    chk("memwr_state", 32'(State), 32'd6);
    chk("memwr_mw", 32'(MemWrite), 32'd1);
    #2 RST = 1'b1;
    #1;
    chk("rst_mid_mw", 32'(MemWrite), 32'd0);
    chk("rst_mid_state", 32'(State), 32'd0);
    chk("rst_mid_outs", 32'(outs), 32'd0);
    exp_done--;
    @(posedge CLK); #1;
    chk("rst_hold_state", 32'(State), 32'd0);
    RST = 1'b0;
    cur_op = '0;
    q.push_back('{0, 18'd0, 1'b1, 6'd0});
    build(LW);
    build(6'b111111);
    drain();

    chk("done_count", 32'(seen_done), 32'(exp_done));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
